// File: rtl/ulut_array.sv
// ulut_array: NCH independent K-input LUT channels with a runtime-loaded
// configuration and an output mismatch counter for gate characterisation.
// Configuration words stream into a shadow chain over a valid/ready
// handshake and are committed to the active tables in a single edge.
// Each channel can drive its output combinationally or through a one-cycle
// pipeline register.

module ulut_array #(
    parameter int K   = 4,   // inputs per LUT channel
    parameter int NCH = 6,   // number of LUT channels
    parameter int CW  = 8,   // configuration word width
    parameter int ECW = 16   // error counter width
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NCH*K-1:0]   in,
    output logic [NCH-1:0]     out,
    input  logic               cfg_start,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [CW-1:0]      cfg_data,
    output logic               cfg_busy,
    output logic               cfg_done,
    input  logic               chk_en,
    input  logic               chk_clr,
    input  logic [NCH-1:0]     exp,
    output logic [ECW-1:0]     err_cnt
);

    // Per-channel slice: 2^K table bits followed by one regsel bit.
    localparam int TW   = 1 << K;
    localparam int SW   = TW + 1;
    localparam int CB   = NCH * SW;
    localparam int NW   = (CB + CW - 1) / CW;
    localparam int SHW  = NW * CW;
    localparam int CNTW = (NW > 1) ? $clog2(NW) : 1;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        COMMIT
    } state_t;

    state_t            state;
    logic [CNTW-1:0]   word_cnt;
    logic [SHW-1:0]    shadow;
    logic [CB-1:0]     active;
    logic [NCH-1:0]    lut;
    logic [NCH-1:0]    regsel;
    logic [NCH-1:0]    pipe;
    logic              handshake;

    // A word moves only while loading; start in the same cycle wins.
    assign handshake = cfg_valid && cfg_ready && !cfg_start;

    // Load/commit controller with registered handshake and status outputs.
    // NOTE: sequential state is updated with non-blocking assignments so every
    // register samples the pre-edge values, independent of statement order.
    // NOTE: shadow and active are plain registers (not RAM), and a reset must
    // leave an all-zero configuration, so they sit on the async reset too.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            word_cnt  <= '0;
            shadow    <= '0;
            active    <= '0;
            cfg_ready <= 1'b0;
            cfg_busy  <= 1'b0;
            cfg_done  <= 1'b0;
        end else begin
            cfg_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (cfg_start) begin
                        state     <= LOAD;
                        word_cnt  <= '0;
                        cfg_ready <= 1'b1;
                        cfg_busy  <= 1'b1;
                    end
                end
                LOAD: begin
                    if (cfg_start) begin
                        word_cnt <= '0;
                    end else if (handshake) begin
                        shadow <= SHW'({cfg_data, shadow} >> CW);
                        if (word_cnt == CNTW'(NW - 1)) begin
                            state     <= COMMIT;
                            word_cnt  <= '0;
                            cfg_ready <= 1'b0;
                        end else begin
                            word_cnt <= word_cnt + CNTW'(1);
                        end
                    end
                end
                COMMIT: begin
                    active   <= shadow[CB-1:0];
                    cfg_done <= 1'b1;
                    cfg_busy <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    state     <= IDLE;
                    cfg_ready <= 1'b0;
                    cfg_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Table lookup and regsel extraction for every channel.
    always_comb begin
        logic [TW-1:0] tbl;
        // NOTE: every always_comb output gets a default first so no path
        // through the block can leave a value held, which would infer a latch.
        lut    = '0;
        regsel = '0;
        tbl    = '0;
        for (int c = 0; c < NCH; c++) begin
            tbl       = active[c*SW +: TW];
            lut[c]    = tbl[in[c*K +: K]];
            regsel[c] = active[c*SW + TW];
        end
    end

    // Free-running output pipeline, so toggling regsel never needs a refill.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe <= '0;
        end else begin
            pipe <= lut;
        end
    end

    assign out = (regsel & pipe) | (~regsel & lut);

    // Saturating mismatch counter against the out value visible this cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt <= '0;
        end else if (chk_clr) begin
            err_cnt <= '0;
        end else if (chk_en && (out != exp) && (err_cnt != '1)) begin
            err_cnt <= err_cnt + ECW'(1);
        end
    end

endmodule
